// File: rtl/serial_frame_pkg.sv
// ---------------------------------------------------------------------------
// serial_frame_pkg
//   Definitions shared by the serial frame transmit and receive paths:
//   - tx_state_e   : transmitter phase encoding
//   - LEN_W        : width of the length field carried in every frame
//   - SYNC_W_DEF   : default sync pattern width
//   - SYNC_PAT_DEF : default sync pattern, sent MSB first
// ---------------------------------------------------------------------------
package serial_frame_pkg;

    localparam int LEN_W = 8;

    localparam int                    SYNC_W_DEF   = 4;
    localparam logic [SYNC_W_DEF-1:0] SYNC_PAT_DEF = 4'b1101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_GAP     = 3'd4
    } tx_state_e;

endpackage : serial_frame_pkg

// File: rtl/serial_frame_tx_bit_counter.sv
// ---------------------------------------------------------------------------
// tx_bit_counter
//   Loadable down counter that times every phase of the transmitter. It is
//   loaded with (phase length - 1) on entry to a phase, counts down while
//   enabled and stops at zero; co flags the last cycle of the phase.
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset, clears the count
//   load     in   load load_val (has priority over en)
//   en       in   count down by one (holds at zero)
//   load_val in   LEN_W value to load
//   count    out  current count
//   co       out  count is zero
// ---------------------------------------------------------------------------
module tx_bit_counter
    import serial_frame_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [LEN_W-1:0] load_val,
    output logic [LEN_W-1:0] count,
    output logic             co
);

    // NOTE: sequential state is always written with non-blocking assignments
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign co = (count == '0);

endmodule : tx_bit_counter

// File: rtl/serial_frame_tx.sv
// ---------------------------------------------------------------------------
// serial_frame_tx
//   Serial frame transmitter. On an accepted start it sends SYNC_PAT, an
//   8-bit length N and N payload bits on sout, one bit per cycle, then holds
//   the line idle for GAP_CYC cycles before accepting the next start.
// Parameters
//   SYNC_W    sync pattern width (1..8)
//   SYNC_PAT  sync pattern, sent MSB first
//   GAP_CYC   idle cycles after the frame before ready (>=1)
//   IDLE_LVL  sout level outside a frame
// Ports
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset, aborts any frame
//   start         in   frame request, sampled only while ready=1
//   len           in   payload length N, captured with start
//   pay_bit       in   payload bit, sampled on each edge where pay_rd=1
//   pay_rd        out  registered payload pull strobe
//   sout          out  registered serial line
//   frame_active  out  high while sync/length/payload bits are on sout
//   ready         out  idle, start will be accepted
//   done          out  one-cycle pulse in the first gap cycle
// ---------------------------------------------------------------------------
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int                SYNC_W   = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
    parameter int                GAP_CYC  = 2,
    parameter logic              IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             pay_bit,
    output logic             pay_rd,
    output logic             sout,
    output logic             frame_active,
    output logic             ready,
    output logic             done
);

    // Header shift register holds the sync and length bits still to be sent.
    localparam int FW = SYNC_W + LEN_W;

    tx_state_e        state, state_n;
    logic [FW-1:0]    fsr;
    logic [FW-1:0]    fsr_init;
    logic [LEN_W-1:0] len_q;

    logic             cnt_load;
    logic             cnt_en;
    logic [LEN_W-1:0] cnt_val;
    logic [LEN_W-1:0] count;
    logic             co;

    logic             fsr_load;
    logic             fsr_shift;
    logic             sout_n;
    logic             pay_rd_n;
    logic             done_n;

    assign fsr_init = {SYNC_PAT, len};

    tx_bit_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .count    (count),
        .co       (co)
    );

    // ---------------------------------------------------------------------
    // Next-state and next-output logic. sout, pay_rd and done are computed
    // one cycle ahead and registered, so they line up with the new state.
    // ---------------------------------------------------------------------
    // NOTE: every signal is given a default before the case statement, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_val   = '0;
        fsr_load  = 1'b0;
        fsr_shift = 1'b0;
        sout_n    = IDLE_LVL;
        pay_rd_n  = 1'b0;
        done_n    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n  = ST_SYNC;
                    cnt_load = 1'b1;
                    cnt_val  = LEN_W'(SYNC_W - 1);
                    fsr_load = 1'b1;
                    sout_n   = SYNC_PAT[SYNC_W-1];
                end
            end

            ST_SYNC: begin
                // The bit after the last sync bit is the length MSB, so the
                // shift continues seamlessly into the LEN phase.
                sout_n    = fsr[FW-1];
                fsr_shift = 1'b1;
                if (co) begin
                    state_n  = ST_LEN;
                    cnt_load = 1'b1;
                    cnt_val  = LEN_W'(LEN_W - 1);
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_LEN: begin
                if (co) begin
                    if (len_q == '0) begin
                        state_n  = ST_GAP;
                        cnt_load = 1'b1;
                        cnt_val  = LEN_W'(GAP_CYC - 1);
                        done_n   = 1'b1;
                    end else begin
                        // pay_rd was high in this last LEN cycle, so pay_bit
                        // is the first payload bit.
                        state_n  = ST_PAYLOAD;
                        cnt_load = 1'b1;
                        cnt_val  = len_q - 1'b1;
                        sout_n   = pay_bit;
                        pay_rd_n = (len_q >= LEN_W'(2));
                    end
                end else begin
                    sout_n    = fsr[FW-1];
                    fsr_shift = 1'b1;
                    cnt_en    = 1'b1;
                    // Raise pay_rd for the last LEN cycle.
                    pay_rd_n  = (count == LEN_W'(1)) && (len_q != '0);
                end
            end

            ST_PAYLOAD: begin
                if (co) begin
                    state_n  = ST_GAP;
                    cnt_load = 1'b1;
                    cnt_val  = LEN_W'(GAP_CYC - 1);
                    done_n   = 1'b1;
                end else begin
                    sout_n   = pay_bit;
                    cnt_en   = 1'b1;
                    // No pull in the final payload cycle: its bit was
                    // already fetched one cycle earlier.
                    pay_rd_n = (count >= LEN_W'(2));
                end
            end

            ST_GAP: begin
                if (co) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            sout   <= IDLE_LVL;
            pay_rd <= 1'b0;
            done   <= 1'b0;
            fsr    <= '0;
            len_q  <= '0;
        end else begin
            state  <= state_n;
            sout   <= sout_n;
            pay_rd <= pay_rd_n;
            done   <= done_n;
            if (fsr_load) begin
                // First sync bit goes straight to sout; keep the rest.
                fsr   <= fsr_init << 1;
                len_q <= len;
            end else if (fsr_shift) begin
                fsr <= fsr << 1;
            end
        end
    end

    assign ready        = (state == ST_IDLE);
    assign frame_active = (state == ST_SYNC) || (state == ST_LEN) ||
                          (state == ST_PAYLOAD);

endmodule : serial_frame_tx

// File: tb/tb_serial_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_tx
//   Self-checking bench for serial_frame_tx with SYNC_PAT=1101, GAP_CYC=2,
//   IDLE_LVL=0. Outputs are sampled on the falling edge; pay_bit is driven
//   on the falling edge of every cycle where pay_rd=1.
// ---------------------------------------------------------------------------
module tb_serial_frame_tx;
    import serial_frame_pkg::*;

    localparam int         SW  = 4;
    localparam logic [3:0] PAT = 4'b1101;
    localparam int         GAP = 2;
    localparam int         HDR = SW + LEN_W;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       pay_bit;
    logic       pay_rd;
    logic       sout;
    logic       frame_active;
    logic       ready;
    logic       done;

    serial_frame_tx #(
        .SYNC_W   (SW),
        .SYNC_PAT (PAT),
        .GAP_CYC  (GAP),
        .IDLE_LVL (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .pay_bit      (pay_bit),
        .pay_rd       (pay_rd),
        .sout         (sout),
        .frame_active (frame_active),
        .ready        (ready),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Directed frame vectors: expected sout stream right-aligned, MSB first.
    typedef struct {
        logic [7:0]  len;
        logic [15:0] pay;       // payload source bits, MSB sent first
        int          nbits;
        logic [31:0] exp_sout;
        int          exp_done;
        int          exp_ready;
    } vec_t;

    vec_t vecs[5];

    bit src_q[$];   // directed payload source; random when empty
    bit sb_q[$];    // every payload bit handed to the DUT
    bit rx_q[$];    // every sout sample, one per cycle

    logic [31:0] obs_sout;
    int obs_done_first, obs_done_last, obs_done_cnt;
    int obs_ready_first, obs_rd_cnt, obs_rd_first, obs_fa_cnt;

    task automatic clear_obs();
        obs_sout        = '0;
        obs_done_first  = 0;
        obs_done_last   = 0;
        obs_done_cnt    = 0;
        obs_ready_first = 0;
        obs_rd_cnt      = 0;
        obs_rd_first    = 0;
        obs_fa_cnt      = 0;
        rx_q.delete();
    endtask

    // Advance to the falling edge of cycle c, record outputs, feed pay_bit.
    task automatic cycle_obs(input int c, input int nbits);
        bit b;
        @(negedge clk);
        rx_q.push_back(sout);
        if (c <= nbits && c <= 32) obs_sout = {obs_sout[30:0], sout};
        if (done) begin
            obs_done_cnt++;
            obs_done_last = c;
            if (obs_done_first == 0) obs_done_first = c;
        end
        if (ready && obs_ready_first == 0) obs_ready_first = c;
        if (pay_rd) begin
            obs_rd_cnt++;
            if (obs_rd_first == 0) obs_rd_first = c;
            if (src_q.size() != 0) b = src_q.pop_front();
            else b = 1'($urandom_range(0, 1));
            pay_bit = b;
            sb_q.push_back(b);
        end
        if (frame_active) obs_fa_cnt++;
    endtask

    // Send one frame from a vector; optionally pulse start at cycle glitch_cyc.
    // Called at a falling edge with the DUT idle.
    task automatic run_vec(input int idx, input int glitch_cyc);
        vec_t v;
        v = vecs[idx];
        clear_obs();
        src_q.delete();
        for (int k = 0; k < int'(v.len); k++) src_q.push_back(v.pay[15-k]);
        start = 1'b1;
        len   = v.len;
        for (int c = 1; c <= v.exp_ready; c++) begin
            cycle_obs(c, v.nbits);
            start = (c == glitch_cyc);
            len   = ~v.len;   // mid-frame length changes must be ignored
        end
        check($sformatf("v%0d sout", idx), obs_sout, v.exp_sout);
        check($sformatf("v%0d done_cyc", idx), obs_done_first, v.exp_done);
        check($sformatf("v%0d done_cnt", idx), obs_done_cnt, 1);
        check($sformatf("v%0d ready_cyc", idx), obs_ready_first, v.exp_ready);
        check($sformatf("v%0d pay_rd_cnt", idx), obs_rd_cnt, 32'(v.len));
        check($sformatf("v%0d pay_rd_first", idx), obs_rd_first, (v.len != 0) ? HDR : 0);
        check($sformatf("v%0d fa_cnt", idx), obs_fa_cnt, v.nbits);
    endtask

    // Receive-side model: hunt for sync, load length, count payload down.
    task automatic rx_model(output int rlen_o, output int done_cyc, output int bad);
        int         st;
        logic [3:0] sh;
        logic [7:0] rlen;
        int         k, rem, idx;
        st = 0; sh = '0; rlen = '0; k = 0; rem = 0; idx = 0;
        rlen_o = -1; done_cyc = -1; bad = 0;
        for (int i = 0; i < rx_q.size(); i++) begin
            case (st)
                0: begin
                    sh = {sh[2:0], rx_q[i]};
                    if (sh == PAT) st = 1;
                end
                1: begin
                    rlen = {rlen[6:0], rx_q[i]};
                    k++;
                    if (k == 8) begin
                        rlen_o = int'(rlen);
                        rem    = int'(rlen);
                        st     = (rem == 0) ? 3 : 2;
                    end
                end
                2: begin
                    if (idx >= sb_q.size() || rx_q[i] != sb_q[idx]) bad++;
                    idx++;
                    rem--;
                    if (rem == 0) begin
                        done_cyc = i + 1;
                        st       = 3;
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        bit exp_q[$];
        int bad, rl, dc, nmis, idle_hi;
        logic [7:0] n;
        logic [11:0] hdr;

        vecs[0] = '{8'd3,  16'hA000, 15, 32'({4'b1101, 8'd3,  3'b101}),   16, 18};
        vecs[1] = '{8'd0,  16'h0000, 12, 32'({4'b1101, 8'd0}),            13, 15};
        vecs[2] = '{8'd1,  16'h8000, 13, 32'({4'b1101, 8'd1,  1'b1}),     14, 16};
        vecs[3] = '{8'd5,  16'h6800, 17, 32'({4'b1101, 8'd5,  5'b01101}), 18, 20};
        vecs[4] = '{8'd16, 16'hC3A5, 28, 32'({4'b1101, 8'd16, 16'hC3A5}), 29, 31};

        rst = 1'b1; start = 1'b0; len = '0; pay_bit = 1'b0;
        #3;
        check("rst sout",   32'(sout), 0);
        check("rst ready",  32'(ready), 1);
        check("rst fa",     32'(frame_active), 0);
        check("rst pay_rd", 32'(pay_rd), 0);
        check("rst done",   32'(done), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk); @(negedge clk);
        check("idle ready", 32'(ready), 1);
        check("idle sout",  32'(sout), 0);

        // Directed table.
        for (int i = 0; i < 5; i++) run_vec(i, 0);

        // start pulse mid-frame is ignored: one frame, then a quiet line.
        run_vec(0, 5);
        idle_hi = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sout || frame_active || !ready) idle_hi++;
        end
        check("glitch no 2nd frame", idle_hi, 0);

        // Reset during LEN aborts the frame.
        clear_obs();
        src_q.delete();
        start = 1'b1; len = 8'd3;
        for (int c = 1; c <= 7; c++) begin
            cycle_obs(c, 0);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("abort sout",   32'(sout), 0);
        check("abort ready",  32'(ready), 1);
        check("abort fa",     32'(frame_active), 0);
        check("abort pay_rd", 32'(pay_rd), 0);
        @(negedge clk);
        check("abort hold ready", 32'(ready), 1);
        rst = 1'b0;
        @(negedge clk);
        run_vec(0, 0);

        // Back-to-back N=255 frames with start held high.
        clear_obs();
        src_q.delete();
        sb_q.delete();
        start = 1'b1; len = 8'd255;
        for (int c = 1; c <= 545; c++) begin
            cycle_obs(c, 0);
            if (c == 300) start = 1'b0;
        end
        hdr = {4'b1101, 8'hFF};
        exp_q.delete();
        for (int f = 0; f < 2; f++) begin
            for (int k = 11; k >= 0; k--) exp_q.push_back(hdr[k]);
            for (int k = 0; k < 255; k++)
                exp_q.push_back((f * 255 + k < sb_q.size()) ? sb_q[f * 255 + k] : 1'b0);
            for (int k = 0; k < ((f == 0) ? 3 : 8); k++) exp_q.push_back(1'b0);
        end
        nmis = 0;
        for (int i = 0; i < 545; i++) if (rx_q[i] != exp_q[i]) nmis++;
        check("b2b stream miscompares", nmis, 0);
        check("b2b pay bits pulled", sb_q.size(), 510);
        check("b2b done1 cyc", obs_done_first, 268);
        check("b2b done2 cyc", obs_done_last, 538);
        check("b2b done cnt", obs_done_cnt, 2);
        check("b2b ready cyc", obs_ready_first, 270);
        check("b2b fa cnt", obs_fa_cnt, 534);

        // Loopback into a receive-side model with random lengths.
        for (int t = 0; t < 3; t++) begin
            n = 8'($urandom_range(1, 40));
            clear_obs();
            src_q.delete();
            sb_q.delete();
            start = 1'b1; len = n;
            for (int c = 1; c <= HDR + int'(n) + GAP + 1; c++) begin
                cycle_obs(c, 0);
                start = 1'b0;
            end
            rx_model(rl, dc, bad);
            check($sformatf("loop%0d rx len", t), rl, 32'(n));
            check($sformatf("loop%0d rx done cyc", t), dc, HDR + int'(n));
            check($sformatf("loop%0d rx payload", t), bad, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_serial_frame_tx
